// File: rtl/clock_run_ctrl_if.sv
// rtl/clock_run_ctrl_if.sv - control/status bundle between clock-run controller and its driver
interface clock_run_ctrl_if #(
  parameter int CNT_WIDTH = 32,
  parameter int STEP_W    = 8
);
  logic                 ctrl;
  logic [1:0]           mode;
  logic [STEP_W-1:0]    step_count;
  logic                 halt;
  logic                 clock_ctrl;
  logic                 clk_en;
  logic                 running;
  logic [CNT_WIDTH-1:0] remaining;
  logic                 done;

  modport master (
    output ctrl, mode, step_count, halt,
    input  clock_ctrl, clk_en, running, remaining, done
  );

  modport slave (
    input  ctrl, mode, step_count, halt,
    output clock_ctrl, clk_en, running, remaining, done
  );
endinterface

// File: rtl/clock_run_ctrl.sv
// rtl/clock_run_ctrl.sv - gates the board clock into the CPU clock in off/free/timed/step modes
module clock_run_ctrl #(
  parameter int          CNT_WIDTH    = 32,
  parameter int unsigned TIMEOUT      = 500000000,
  parameter int          STEP_W       = 8,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic          clock,
  input  logic          rst,
  clock_run_ctrl_if.slave bus
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_FREE  = 2'b01;
  localparam logic [1:0] MODE_TIMED = 2'b10;
  localparam logic [1:0] MODE_STEP  = 2'b11;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LOAD = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FREE  = 2'd1,
    S_COUNT = 2'd2
  } state_t;

  state_t               state;
  logic                 ctrl_q;
  logic                 start_q;   // first cycle after reset behaves as a timed-run load
  logic                 clk_en_q;
  logic                 running_q;
  logic                 done_q;
  logic                 gate_q;
  logic [CNT_WIDTH-1:0] remaining_q;
  logic                 trig;
  logic [CNT_WIDTH-1:0] step_load;

  assign trig      = bus.ctrl & ~ctrl_q;
  assign step_load = (bus.step_count == '0) ? CNT_WIDTH'(1) : CNT_WIDTH'(bus.step_count);

  // Run-state FSM: priority rst > halt > OFF > FREE > trigger/load > decrement
  always_ff @(posedge clock) begin
    if (rst) begin
      ctrl_q      <= 1'b0;
      done_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      running_q   <= 1'b0;
      start_q     <= RUN_ON_RESET;
      state       <= RUN_ON_RESET ? S_COUNT : S_IDLE;
      remaining_q <= RUN_ON_RESET ? TIMEOUT_LOAD : '0;
    end else begin
      ctrl_q  <= bus.ctrl;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (bus.halt || bus.mode == MODE_OFF) begin
        state       <= S_IDLE;
        remaining_q <= '0;
        clk_en_q    <= 1'b0;
        running_q   <= 1'b0;
      end else if (bus.mode == MODE_FREE) begin
        state       <= S_FREE;
        remaining_q <= '0;
        clk_en_q    <= 1'b1;
        running_q   <= 1'b1;
      end else if (state == S_FREE) begin
        state       <= S_IDLE;
        remaining_q <= '0;
        clk_en_q    <= 1'b0;
        running_q   <= 1'b0;
      end else if (start_q || (trig && bus.mode == MODE_TIMED)) begin
        state       <= S_COUNT;
        remaining_q <= TIMEOUT_LOAD;
        clk_en_q    <= 1'b1;
        running_q   <= 1'b1;
      end else if (trig && bus.mode == MODE_STEP && state == S_IDLE) begin
        state       <= S_COUNT;
        remaining_q <= step_load;
        clk_en_q    <= 1'b1;
        running_q   <= 1'b1;
      end else if (state == S_COUNT) begin
        if (remaining_q <= CNT_WIDTH'(1)) begin
          state       <= S_IDLE;
          remaining_q <= '0;
          clk_en_q    <= 1'b0;
          running_q   <= 1'b0;
          done_q      <= 1'b1;
        end else begin
          remaining_q <= remaining_q - CNT_WIDTH'(1);
        end
      end else begin
        state       <= S_IDLE;
        remaining_q <= '0;
        clk_en_q    <= 1'b0;
        running_q   <= 1'b0;
      end
    end
  end

  // Gate updates while clock is low so every gated pulse is full width
  always_ff @(negedge clock) begin
    if (rst) gate_q <= 1'b0;
    else     gate_q <= clk_en_q;
  end

  assign bus.clock_ctrl = clock & gate_q;
  assign bus.clk_en     = clk_en_q;
  assign bus.running    = running_q;
  assign bus.remaining  = remaining_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_clock_run_ctrl.sv
// tb/tb_clock_run_ctrl.sv - directed self-checking bench for clock_run_ctrl
module tb_clock_run_ctrl;
  logic       clock = 1'b0;
  logic       rst;
  logic       ctrl;
  logic [1:0] mode;
  logic [7:0] step_count;
  logic       halt;

  int tests  = 0;
  int failed = 0;
  int en_a, en_b, done_a, done_b, pulses_a, pulses_b;

  always #5 clock = ~clock;

  clock_run_ctrl_if #(.CNT_WIDTH(32), .STEP_W(8)) a_if ();
  clock_run_ctrl_if #(.CNT_WIDTH(32), .STEP_W(8)) b_if ();

  assign a_if.ctrl = ctrl;  assign a_if.mode = mode;
  assign a_if.step_count = step_count;  assign a_if.halt = halt;
  assign b_if.ctrl = ctrl;  assign b_if.mode = mode;
  assign b_if.step_count = step_count;  assign b_if.halt = halt;

  // a: timed run on leaving reset, 5-cycle timeout
  clock_run_ctrl #(.CNT_WIDTH(32), .TIMEOUT(5), .STEP_W(8), .RUN_ON_RESET(1'b1)) dut_a (
    .clock(clock), .rst(rst), .bus(a_if.slave));
  // b: idle after reset, 10-cycle timeout
  clock_run_ctrl #(.CNT_WIDTH(32), .TIMEOUT(10), .STEP_W(8), .RUN_ON_RESET(1'b0)) dut_b (
    .clock(clock), .rst(rst), .bus(b_if.slave));

  always @(posedge a_if.clock_ctrl) pulses_a <= pulses_a + 1;
  always @(posedge b_if.clock_ctrl) pulses_b <= pulses_b + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic zero();
    en_a = 0; en_b = 0; done_a = 0; done_b = 0; pulses_a = 0; pulses_b = 0;
  endtask

  // one clock: sample 1 time unit after posedge, accumulate enable/done counts
  task automatic tick();
    @(posedge clock);
    #1;
    en_a   += int'(a_if.clk_en);
    en_b   += int'(b_if.clk_en);
    done_a += int'(a_if.done);
    done_b += int'(b_if.done);
  endtask

  initial begin
    rst = 1'b1; ctrl = 1'b0; mode = 2'b10; step_count = 8'd0; halt = 1'b0;
    pulses_a = 0; pulses_b = 0;
    repeat (3) tick();
    check("rst_a_clk_en", 32'(a_if.clk_en), 0);
    check("rst_a_remaining", a_if.remaining, 5);
    check("rst_a_running", 32'(a_if.running), 0);
    check("rst_a_done", 32'(a_if.done), 0);
    check("rst_b_remaining", b_if.remaining, 0);
    check("rst_b_clk_en", 32'(b_if.clk_en), 0);

    // 1: run on reset release, TIMEOUT=5
    zero(); rst = 1'b0;
    tick();
    check("t1_first_en", 32'(a_if.clk_en), 1);
    check("t1_first_rem", a_if.remaining, 5);
    repeat (8) tick();
    check("t1_en_cycles", en_a, 5);
    check("t1_done", done_a, 1);
    check("t1_pulses", pulses_a, 5);
    check("t1_b_idle", en_b, 0);

    // 2: step of 3, step of 0 -> 1, retrigger ignored in STEP
    mode = 2'b11; step_count = 8'd3; zero();
    ctrl = 1'b1; tick(); ctrl = 1'b0;
    check("t2_load3", b_if.remaining, 3);
    repeat (6) tick();
    check("t2_en3", en_b, 3);
    check("t2_done3", done_b, 1);
    check("t2_pulses3", pulses_b, 3);
    step_count = 8'd0; zero();
    ctrl = 1'b1; tick(); ctrl = 1'b0;
    repeat (4) tick();
    check("t2_en0", en_b, 1);
    check("t2_pulses0", pulses_b, 1);
    check("t2_done0", done_b, 1);
    step_count = 8'd3; zero();
    ctrl = 1'b1; tick(); ctrl = 1'b0; tick(); ctrl = 1'b1; tick(); ctrl = 1'b0;
    repeat (5) tick();
    check("t2_retrig_ignored", en_b, 3);

    // 3: timed retrigger on b (TIMEOUT=10)
    mode = 2'b10; zero();
    ctrl = 1'b1; tick(); ctrl = 1'b0;
    repeat (5) tick();
    check("t3_rem5", b_if.remaining, 5);
    ctrl = 1'b1; tick(); ctrl = 1'b0;
    check("t3_reload", b_if.remaining, 10);
    repeat (14) tick();
    check("t3_en16", en_b, 16);
    check("t3_done", done_b, 1);
    check("t3_pulses16", pulses_b, 16);
    // trig coincident with expiry in TIMED: reload, no done
    zero();
    ctrl = 1'b1; tick(); ctrl = 1'b0;
    repeat (9) tick();
    check("t3_rem1", b_if.remaining, 1);
    ctrl = 1'b1; tick(); ctrl = 1'b0;
    check("t3_expiry_reload", b_if.remaining, 10);
    check("t3_expiry_nodone", done_b, 0);
    repeat (12) tick();

    // 4: FREE 20 cycles then OFF
    mode = 2'b01; zero();
    repeat (20) tick();
    check("t4_running", 32'(b_if.running), 1);
    check("t4_en20", en_b, 20);
    check("t4_rem0", b_if.remaining, 0);
    mode = 2'b00; tick();
    check("t4_off_en", 32'(b_if.clk_en), 0);
    check("t4_off_running", 32'(b_if.running), 0);
    repeat (2) tick();
    check("t4_no_done", done_b, 0);
    check("t4_pulses20", pulses_b, 20);

    // 5: halt at remaining=2 in STEP
    mode = 2'b11; step_count = 8'd5; zero();
    ctrl = 1'b1; tick(); ctrl = 1'b0;
    repeat (3) tick();
    check("t5_rem2", b_if.remaining, 2);
    halt = 1'b1; tick();
    check("t5_halt_en", 32'(b_if.clk_en), 0);
    check("t5_halt_rem", b_if.remaining, 0);
    check("t5_halt_running", 32'(b_if.running), 0);
    halt = 1'b0;
    repeat (3) tick();
    check("t5_no_done", done_b, 0);
    check("t5_en4", en_b, 4);

    // 6: reset mid-COUNT with ctrl held high
    mode = 2'b10;
    ctrl = 1'b1; tick(); tick();
    check("t6_a_counting", a_if.remaining, 4);
    rst = 1'b1; tick();
    check("t6_rst_a_en", 32'(a_if.clk_en), 0);
    check("t6_rst_a_rem", a_if.remaining, 5);
    check("t6_rst_a_running", 32'(a_if.running), 0);
    check("t6_rst_b_rem", b_if.remaining, 0);
    repeat (2) tick();
    check("t6_held_ctrl_a", 32'(a_if.clk_en), 0);
    check("t6_held_ctrl_b", 32'(b_if.clk_en), 0);
    ctrl = 1'b0; tick(); zero(); rst = 1'b0;
    repeat (8) tick();
    check("t6_restart_en", en_a, 5);
    check("t6_restart_done", done_a, 1);
    check("t6_b_stays_idle", en_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
